// File: rtl/bus_sched_pkg.sv
// Shared types and constants for the round-robin bus scheduler.
// Optional statistics counters are enabled by BUS_SCHED_STATS_EN.
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    PUSH  = 2'd2
  } state_t;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BDCST_DEF = 8'hFF;
  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bus_rr_scheduler_pick.sv
// Rotating-priority pick: the first requester after last, wrapping.
// Search starts at last+1 so the previous winner has lowest priority.
module bus_rr_pick #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          valid
);

  logic [IW:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      idx = {1'b0, last} + (IW+1)'(i);
      if (idx >= (IW+1)'(N))
        idx = idx - (IW+1)'(N);
      if (!valid && req[idx[IW-1:0]]) begin
        valid  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin bus scheduler: IDLE -> GRANT -> PUSH, one packet per 3 cycles.
// Define BUS_SCHED_STATS_EN to add grant_cnt / drop_cnt outputs.
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int              pckg_sz = 16,
  parameter int              drvrs   = 8,
  parameter logic [ID_W-1:0] bdcst   = BDCST_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push,
  output logic [3:0]                      grant_id,
  output logic                            busy,
  output logic                            drop
`ifdef BUS_SCHED_STATS_EN
  ,
  output logic [drvrs-1:0][CNT_W-1:0]     grant_cnt,
  output logic [CNT_W-1:0]                drop_cnt
`endif
);

  localparam int IW = $clog2(drvrs);

  state_t             state_q, state_d;
  logic [IW-1:0]      win_q;
  logic [IW-1:0]      last_q;
  logic [pckg_sz-1:0] pkt_q;
  logic [IW-1:0]      pick_w;
  logic               pick_v;
  logic [ID_W-1:0]    dest;
  logic               is_bc;
  logic               is_uc;

  bus_rr_pick #(
    .N  (drvrs),
    .IW (IW)
  ) u_pick (
    .req    (pndng),
    .last   (last_q),
    .winner (pick_w),
    .valid  (pick_v)
  );

  assign dest  = pkt_q[pckg_sz-1 -: ID_W];
  assign is_bc = (dest == bdcst);
  assign is_uc = !is_bc && (32'(dest) < drvrs);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_v) state_d = GRANT;
      GRANT:   state_d = PUSH;
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop  = '0;
    push = '0;
    drop = 1'b0;
    if (state_q == GRANT)
      pop[win_q] = 1'b1;
    if (state_q == PUSH) begin
      unique case (1'b1)
        is_bc: begin
          push        = '1;
          push[win_q] = 1'b0;
        end
        is_uc:   push[dest[IW-1:0]] = 1'b1;
        default: drop = 1'b1;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign D_push   = pkt_q;
  assign grant_id = 4'(win_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= IW'(drvrs-1);
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_v)
        win_q <= pick_w;
      if (state_q == GRANT)
        pkt_q <= D_pop[win_q];
      if (state_q == PUSH)
        last_q <= win_q;
    end
  end

`ifdef BUS_SCHED_STATS_EN
  // Counted on leaving PUSH, so aborted transfers are never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
      drop_cnt  <= '0;
    end else if (state_q == PUSH) begin
      grant_cnt[win_q] <= sat_inc(grant_cnt[win_q]);
      if (drop)
        drop_cnt <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule

// File: doc/bus_rr_scheduler.md
BUS_RR_SCHEDULER -- requirements
Module: bus_rr_scheduler

Interface
REQ-001 SHALL have parameter pckg_sz, default 16, packet width in bits (min 9).
REQ-002 SHALL have parameter drvrs, default 8, number of bus drivers (2..16).
REQ-003 SHALL have parameter bdcst, default 8'hFF, broadcast destination id.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pndng  input  drvrs  per-driver FIFO non-empty flag.
REQ-007 SHALL have port D_pop  input  drvrs x pckg_sz  per-driver FIFO head data.
REQ-008 SHALL have port pop  output  drvrs  one-hot pop strobe to the granted driver FIFO.
REQ-009 SHALL have port push  output  drvrs  push strobes to destination FIFOs.
REQ-010 SHALL have port D_push  output  pckg_sz  packet broadcast on the bus.
REQ-011 SHALL have port grant_id  output  4  id of the current or last granted driver.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port drop  output  1  one-cycle pulse when a packet is discarded.

Function
REQ-014 SHALL decode the destination id from D_pop[pckg_sz-1 -: 8].
REQ-015 SHALL run FSM IDLE -> GRANT -> PUSH -> IDLE, with no other states.
REQ-016 SHALL, in IDLE with any pndng set, pick a winner round-robin starting at last_grant+1 modulo drvrs, then enter GRANT.
REQ-017 SHALL, in IDLE with no pndng set, stay in IDLE with pop and push all zero.
REQ-018 SHALL, in GRANT, register D_pop[winner], assert pop[winner] for exactly one cycle, then enter PUSH.
REQ-019 SHALL, in PUSH, drive D_push from the registered packet.
REQ-020 SHALL, in PUSH, assert push[dest] for one cycle when dest < drvrs; a dest equal to the source is delivered.
REQ-021 SHALL, in PUSH with dest == bdcst, assert push on every index except the source.
REQ-022 SHALL, in PUSH with any other dest, assert no push, pulse drop, and still consume the packet.
REQ-023 SHALL update last_grant to the winner on leaving PUSH.
REQ-024 SHALL have latency: pndng seen in IDLE at cycle N, pop at N+1, push at N+2; maximum throughput is one packet per 3 cycles.
REQ-025 SHALL ignore pndng changes during GRANT and PUSH; the winner is fixed from the IDLE decision.
REQ-026 SHALL hold D_push at its last value outside PUSH.

Reset
REQ-027 SHALL, while reset is high at a clock edge, set state to IDLE, last_grant to drvrs-1 (so driver 0 wins first), pop, push, D_push, grant_id and drop to 0, and busy to 0.
REQ-028 SHALL, on reset asserted mid-GRANT or mid-PUSH, abort the transfer with no push on the following cycle.

Configuration
REQ-029 SHALL, when BUS_SCHED_STATS_EN is defined, add output grant_cnt (drvrs x 16), a per-driver saturating count of completed grants.
REQ-030 SHALL, when BUS_SCHED_STATS_EN is defined, add output drop_cnt (16), a saturating count of drops.
REQ-031 SHALL clear both counters on reset.
REQ-032 SHALL, when BUS_SCHED_STATS_EN is undefined, omit these ports and counters entirely.

Structure
REQ-033 SHALL place the state enum, ID_W=8 and the bdcst default in package bus_sched_pkg.
REQ-034 SHALL implement the rotating priority pick as sub-module bus_rr_pick (inputs: req vector, last grant; outputs: winner, valid).

Verification
REQ-035 SHALL cover: after reset, pndng=8'b0000_0001 with D_pop[0]=16'h0355 -> pop[0] at N+1, push[3] with D_push=16'h0355 at N+2.
REQ-036 SHALL cover: pndng=8'hFF held -> grants cycle in order 0,1,...,7,0, one every 3 cycles.
REQ-037 SHALL cover: driver 2 sends 16'hFFAA -> push=8'b1111_1011, D_push=16'hFFAA.
REQ-038 SHALL cover: driver 1 sends dest 8'h20 -> pop[1] pulses, push stays 0, drop pulses once.
REQ-039 SHALL cover: reset raised during GRANT -> no push, and driver 0 wins after release.
REQ-040 SHALL cover, with BUS_SCHED_STATS_EN: 5 grants to driver 4 and 1 drop -> grant_cnt[4]=5, drop_cnt=1.
